// File: rtl/board_serializer.sv
// board_serializer: shifts a 4x4 torus seed board into dataPath one cell per
// cycle (cell 0 first), with hold/abort control and a one-cycle done pulse.
// Optional feature: define BOARD_POPCOUNT_EN to add the pop_count output
// (number of live cells written during the current/last transfer).
module board_serializer #(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned SIZE1 = 4
) (
  input  logic             clka,
  input  logic             restart_n,
  input  logic             seed_valid,
  input  logic [SIZE-1:0]  seed_data,
  output logic             seed_ready,
  input  logic             hold,
  input  logic             abort,
  output logic             DataIn,
  output logic [SIZE1-1:0] count,
  output logic             loadData,
  output logic             writeData,
  output logic             readData,
  output logic             busy,
  output logic             done
`ifdef BOARD_POPCOUNT_EN
  ,
  output logic [4:0]       pop_count
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [SIZE1-1:0] LAST_CELL = SIZE1'(SIZE - 1);

  logic [1:0]       state,    nextState;
  logic [SIZE-1:0]  shiftReg, nextShift;
  logic [SIZE1-1:0] cellCnt,  nextCnt;

`ifdef BOARD_POPCOUNT_EN
  localparam int unsigned POPW = 5;
  logic [POPW-1:0] popCnt, nextPop;
`endif

  // State, shift register and cell counter; reset forces IDLE immediately
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state    <= IDLE;
      shiftReg <= '0;
      cellCnt  <= '0;
`ifdef BOARD_POPCOUNT_EN
      popCnt   <= '0;
`endif
    end else begin
      state    <= nextState;
      shiftReg <= nextShift;
      cellCnt  <= nextCnt;
`ifdef BOARD_POPCOUNT_EN
      popCnt   <= nextPop;
`endif
    end
  end

  // Next-state logic: accept in IDLE, shift per written cell, abort wins over hold and completion
  always_comb begin
    nextState = state;
    nextShift = shiftReg;
    nextCnt   = cellCnt;
`ifdef BOARD_POPCOUNT_EN
    nextPop   = popCnt;
`endif
    case (state)
      IDLE: begin
        if (seed_valid) begin
          nextShift = seed_data;
          nextCnt   = '0;
          nextState = SEND;
`ifdef BOARD_POPCOUNT_EN
          nextPop   = '0;
`endif
        end
      end
      SEND: begin
        if (abort) begin
          nextState = IDLE;
          nextShift = '0;
          nextCnt   = '0;
`ifdef BOARD_POPCOUNT_EN
          nextPop   = '0;
`endif
        end else if (!hold) begin
          nextShift = shiftReg >> 1;
          nextCnt   = cellCnt + SIZE1'(1);
`ifdef BOARD_POPCOUNT_EN
          nextPop   = popCnt + POPW'(shiftReg[0]);
`endif
          if (cellCnt == LAST_CELL) begin
            nextState = DONE;
          end
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Output decode; everything toward dataPath is zero outside SEND
  always_comb begin
    seed_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    DataIn     = 1'b0;
    count      = '0;
    loadData   = 1'b0;
    writeData  = 1'b0;
    case (state)
      IDLE: seed_ready = 1'b1;
      SEND: begin
        busy      = 1'b1;
        DataIn    = shiftReg[0];
        count     = cellCnt;
        loadData  = 1'b1;
        writeData = ~hold;
      end
      DONE: done = 1'b1;
      default: seed_ready = 1'b0;
    endcase
  end

  // dataPath is only ever loaded by this block, never read
  assign readData = 1'b0;

`ifdef BOARD_POPCOUNT_EN
  assign pop_count = popCnt;
`endif

endmodule

// File: tb/tb_board_serializer.sv
// Self-checking bench for board_serializer: cycle model plus directed cases.
module tb_board_serializer;

  logic        clka = 1'b0;
  logic        restart_n;
  logic        seed_valid;
  logic [15:0] seed_data;
  logic        seed_ready;
  logic        hold;
  logic        abort;
  logic        DataIn;
  logic [3:0]  count;
  logic        loadData;
  logic        writeData;
  logic        readData;
  logic        busy;
  logic        done;
`ifdef BOARD_POPCOUNT_EN
  logic [4:0]  pop_count;
`endif

  board_serializer #(.SIZE(16), .SIZE1(4)) dut (
    .clka       (clka),
    .restart_n  (restart_n),
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .seed_ready (seed_ready),
    .hold       (hold),
    .abort      (abort),
    .DataIn     (DataIn),
    .count      (count),
    .loadData   (loadData),
    .writeData  (writeData),
    .readData   (readData),
    .busy       (busy),
    .done       (done)
`ifdef BOARD_POPCOUNT_EN
    ,
    .pop_count  (pop_count)
`endif
  );

  always #5 clka = ~clka;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a transfer walks the seed word bit by bit
  bit          mActive = 1'b0;
  bit          mDone   = 1'b0;
  logic [15:0] mSeed   = '0;
  int          mIdx    = 0;
  int          mPop    = 0;

  always @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      mActive <= 1'b0;
      mDone   <= 1'b0;
      mSeed   <= '0;
      mIdx    <= 0;
      mPop    <= 0;
    end else if (mActive) begin
      if (abort) begin
        mActive <= 1'b0;
        mPop    <= 0;
      end else if (!hold) begin
        mPop <= mPop + int'(mSeed[mIdx]);
        if (mIdx == 15) begin
          mActive <= 1'b0;
          mDone   <= 1'b1;
        end else begin
          mIdx <= mIdx + 1;
        end
      end
    end else if (mDone) begin
      mDone <= 1'b0;
    end else if (seed_valid) begin
      mSeed   <= seed_data;
      mIdx    <= 0;
      mPop    <= 0;
      mActive <= 1'b1;
    end
  end

  // Compare process: every falling edge, all outputs against the model
  always @(negedge clka) begin
    chk("seed_ready", int'(seed_ready), int'(!mActive && !mDone));
    if (!mDone) chk("busy", int'(busy), int'(mActive));
    chk("DataIn",    int'(DataIn),    mActive ? int'(mSeed[mIdx]) : 0);
    chk("count",     int'(count),     mActive ? mIdx : 0);
    chk("loadData",  int'(loadData),  int'(mActive));
    chk("writeData", int'(writeData), int'(mActive && !hold));
    chk("done",      int'(done),      int'(mDone));
    chk("readData",  int'(readData),  0);
`ifdef BOARD_POPCOUNT_EN
    chk("pop_count", int'(pop_count), mPop);
`endif
  end

  // One transfer with optional hold/abort; reports done cycle, return-to-idle cycle, written bits
  task automatic runXfer(input logic [15:0] s, input int holdAt, input int holdLen,
                         input int abortAt, output int doneAt, output int idleAt,
                         output logic [15:0] bits, output int stalls);
    int  hr;
    bit  aborted;
    hr = holdLen; aborted = 1'b0;
    doneAt = 0; idleAt = 0; bits = '0; stalls = 0;
    seed_data  = s;
    seed_valid = 1'b1;
    @(posedge clka); #1;
    seed_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      hold  = 1'b0;
      abort = 1'b0;
      if (busy) begin
        if (!aborted && abortAt >= 0 && int'(count) == abortAt) begin
          abort = 1'b1; aborted = 1'b1;
        end
        if (int'(count) == holdAt && hr > 0) begin
          hold = 1'b1; hr--;
        end
      end
      #1;
      if (loadData && writeData) bits[count] = DataIn;
      if (loadData && !writeData && int'(count) == holdAt) stalls++;
      if (done && doneAt == 0) doneAt = k;
      if (seed_ready && k > 1) begin
        idleAt = k;
        break;
      end
      @(posedge clka); #1;
    end
    hold  = 1'b0;
    abort = 1'b0;
  endtask

  int          dAt, iAt, st;
  logic [15:0] bits;

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    restart_n = 1'b0; seed_valid = 1'b0; seed_data = '0; hold = 1'b0; abort = 1'b0;
    #3;
    chk("rst_seed_ready", int'(seed_ready), 1);
    chk("rst_busy",       int'(busy),       0);
    chk("rst_done",       int'(done),       0);
    chk("rst_count",      int'(count),      0);
    chk("rst_loadData",   int'(loadData),   0);
    chk("rst_writeData",  int'(writeData),  0);
    @(negedge clka); #1;
    restart_n = 1'b1;

    // Plain transfer, first accept right after reset release
    runXfer(16'hA5C3, -1, 0, -1, dAt, iAt, bits, st);
    chk("a5c3_done_at", dAt, 17);
    chk("a5c3_idle_at", iAt, 18);
    chk("a5c3_bits",    int'(bits), int'(16'hA5C3));
`ifdef BOARD_POPCOUNT_EN
    chk("a5c3_pop", int'(pop_count), 8);
`endif

    // Hold three cycles at cell 5
    runXfer(16'hFFFF, 5, 3, -1, dAt, iAt, bits, st);
    chk("hold_done_at", dAt, 20);
    chk("hold_stalls",  st, 3);
    chk("hold_bits",    int'(bits), int'(16'hFFFF));
`ifdef BOARD_POPCOUNT_EN
    chk("hold_pop", int'(pop_count), 16);
`endif

    // Abort at cell 9, then a full transfer of 0001
    runXfer(16'h1234, -1, 0, 9, dAt, iAt, bits, st);
    chk("abort9_done_at", dAt, 0);
    chk("abort9_idle_at", iAt, 11);
`ifdef BOARD_POPCOUNT_EN
    chk("abort9_pop", int'(pop_count), 0);
`endif
    runXfer(16'h0001, -1, 0, -1, dAt, iAt, bits, st);
    chk("after_abort_done_at", dAt, 17);
    chk("after_abort_bits",    int'(bits), 1);

    // Abort coinciding with completion at cell 15
    runXfer(16'hFFFF, -1, 0, 15, dAt, iAt, bits, st);
    chk("abort15_done_at", dAt, 0);
    chk("abort15_idle_at", iAt, 17);

    // Asynchronous reset mid-transfer at cell 7
    seed_data = 16'h3C3C; seed_valid = 1'b1;
    @(posedge clka); #1;
    seed_valid = 1'b0;
    dAt = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy && count == 4'd7) begin
        dAt = 1;
        break;
      end
      @(posedge clka); #1;
    end
    chk("reach_count7", dAt, 1);
    #2;
    restart_n = 1'b0;
    #1;
    chk("async_seed_ready", int'(seed_ready), 1);
    chk("async_busy",       int'(busy),       0);
    chk("async_count",      int'(count),      0);
    chk("async_DataIn",     int'(DataIn),     0);
    chk("async_loadData",   int'(loadData),   0);
    chk("async_writeData",  int'(writeData),  0);
    chk("async_done",       int'(done),       0);
`ifdef BOARD_POPCOUNT_EN
    chk("async_pop", int'(pop_count), 0);
`endif
    @(negedge clka); #1;
    restart_n = 1'b1;

    // Back-to-back seeds with seed_valid held; seed_data change mid-SEND ignored
    seed_data = 16'h00F0; seed_valid = 1'b1;
    @(posedge clka); #1;
    seed_data = 16'hFFFF;
    bits = '0; dAt = 0;
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (loadData && writeData) bits[count] = DataIn;
      if (done) begin
        dAt = k;
        break;
      end
      @(posedge clka); #1;
    end
    chk("b2b_done_at",    dAt, 17);
    chk("b2b_first_bits", int'(bits), int'(16'h00F0));
    @(posedge clka); #2;
    chk("b2b_idle_ready", int'(seed_ready), 1);
    @(posedge clka); #1;
    seed_valid = 1'b0;
    #1;
    chk("b2b_second_busy",  int'(busy),  1);
    chk("b2b_second_count", int'(count), 0);
    bits = '0; dAt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (loadData && writeData) bits[count] = DataIn;
      if (done) begin
        dAt = k;
        break;
      end
      @(posedge clka); #2;
    end
    chk("b2b_second_done_at", dAt, 17);
    chk("b2b_second_bits",    int'(bits), int'(16'hFFFF));

    repeat (3) @(posedge clka);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
